writeback_stage: RTL and testbench

//   MEM/WB pipeline register plus writeback logic of the MIPS datapath; the writer side of the register file.

---
 rtl/mips_wb_pkg.sv | 16 +
 rtl/load_extend.sv | 43 ++++
 rtl/writeback_stage.sv | 142 ++++++++++++++
 tb/tb_writeback_stage.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// mips_wb_pkg: shared encodings for the MIPS writeback stage.
//   RES_*  2-bit result-select codes (mem_result_sel_i)
//   LD_*   3-bit load-type codes (mem_load_type_i); unlisted codes behave as LD_W
package mips_wb_pkg;

    localparam logic [1:0] RES_ALU  = 2'b00;
    localparam logic [1:0] RES_LOAD = 2'b01;
    localparam logic [1:0] RES_LINK = 2'b10;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

endpackage

// File: rtl/load_extend.sv
// load_extend: combinational sub-word load alignment and extension (little-endian).
//   data_i       in  WIDTH  raw data-memory word
//   byte_off_i   in  2      address[1:0] of the load
//   load_type_i  in  3      LD_* code
//   ext_o        out WIDTH  aligned, sign/zero-extended load result
// Assumes WIDTH >= 32.
module load_extend
    import mips_wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       byte_off_i,
    input  logic [2:0]       load_type_i,
    output logic [WIDTH-1:0] ext_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        unique case (byte_off_i)
            2'd0:    byte_sel = data_i[7:0];
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            default: byte_sel = data_i[31:24];
        endcase
        // Halfword alignment only looks at bit 1; bit 0 is ignored.
        half_sel = byte_off_i[1] ? data_i[31:16] : data_i[15:0];
    end

    always_comb begin
        ext_o = data_i;
        case (load_type_i)
            LD_H:    ext_o = {{(WIDTH-16){half_sel[15]}}, half_sel};
            LD_HU:   ext_o = {{(WIDTH-16){1'b0}}, half_sel};
            LD_B:    ext_o = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
            LD_BU:   ext_o = {{(WIDTH-8){1'b0}}, byte_sel};
            default: ext_o = data_i;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline register plus writeback logic (register-file writer).
//   clk, reset               clock; asynchronous active-high reset
//   stall_i, flush_i         hold WB contents / insert bubble (flush wins)
//   mem_*                    MEM-stage instruction fields captured into WB
//   reg_write_WE3_o          register-file write enable ($zero writes suppressed)
//   write_register_A3_o      register-file write address (registered rd)
//   write_data_WD3_o         register-file write data (ALU / load / link)
//   wb_valid_o               WB entry valid
//   retired_count_o          retired-instruction count (wraps)
// Optional feature, macro WB_FWD_EN: adds wb_fwd_valid_o / wb_fwd_rd_o / wb_fwd_data_o
// mirroring WE3 / A3 / WD3 for the forwarding unit.
module writeback_stage
    import mips_wb_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SIZE  = 5,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic             mem_valid_i,
    input  logic             mem_reg_write_i,
    input  logic [SIZE-1:0]  mem_rd_i,
    input  logic [1:0]       mem_result_sel_i,
    input  logic [2:0]       mem_load_type_i,
    input  logic [1:0]       mem_byte_off_i,
    input  logic [WIDTH-1:0] mem_alu_result_i,
    input  logic [WIDTH-1:0] mem_read_data_i,
    input  logic [WIDTH-1:0] mem_pc_plus4_i,
    output logic             reg_write_WE3_o,
    output logic [SIZE-1:0]  write_register_A3_o,
    output logic [WIDTH-1:0] write_data_WD3_o,
    output logic             wb_valid_o,
    output logic [CNT_W-1:0] retired_count_o
`ifdef WB_FWD_EN
    ,
    output logic             wb_fwd_valid_o,
    output logic [SIZE-1:0]  wb_fwd_rd_o,
    output logic [WIDTH-1:0] wb_fwd_data_o
`endif
);

    logic             valid_q, valid_d;
    logic             reg_write_q, reg_write_d;
    logic [SIZE-1:0]  rd_q, rd_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       ltype_q, ltype_d;
    logic [1:0]       off_q, off_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [WIDTH-1:0] pc4_q, pc4_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] load_ext;

    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        rd_d        = rd_q;
        sel_d       = sel_q;
        ltype_d     = ltype_q;
        off_d       = off_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        if (flush_i) begin
            // Only validity is cleared; the payload fields are simply held.
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d     = mem_valid_i;
            reg_write_d = mem_reg_write_i;
            rd_d        = mem_rd_i;
            sel_d       = mem_result_sel_i;
            ltype_d     = mem_load_type_i;
            off_d       = mem_byte_off_i;
            alu_d       = mem_alu_result_i;
            rdata_d     = mem_read_data_i;
            pc4_d       = mem_pc_plus4_i;
        end
        // An entry retires when it leaves WB; a flush does not cancel that.
        count_d = count_q;
        if (valid_q && !stall_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            rd_q        <= '0;
            sel_q       <= '0;
            ltype_q     <= '0;
            off_q       <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            count_q     <= '0;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            rd_q        <= rd_d;
            sel_q       <= sel_d;
            ltype_q     <= ltype_d;
            off_q       <= off_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
            count_q     <= count_d;
        end
    end

    load_extend #(
        .WIDTH(WIDTH)
    ) u_load_extend (
        .data_i     (rdata_q),
        .byte_off_i (off_q),
        .load_type_i(ltype_q),
        .ext_o      (load_ext)
    );

    always_comb begin
        case (sel_q)
            RES_LOAD: write_data_WD3_o = load_ext;
            RES_LINK: write_data_WD3_o = pc4_q;
            default:  write_data_WD3_o = alu_q;
        endcase
    end

    assign reg_write_WE3_o     = valid_q & reg_write_q & (rd_q != '0);
    assign write_register_A3_o = rd_q;
    assign wb_valid_o          = valid_q;
    assign retired_count_o     = count_q;

`ifdef WB_FWD_EN
    assign wb_fwd_valid_o = reg_write_WE3_o;
    assign wb_fwd_rd_o    = write_register_A3_o;
    assign wb_fwd_data_o  = write_data_WD3_o;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: scoreboard bench for writeback_stage (CNT_W=4 to exercise wrap).
module tb_writeback_stage;
    import mips_wb_pkg::*;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] pc4;
        logic [31:0] exp_wd;
        logic        exp_we;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_i, flush_i;
    logic        mem_valid_i, mem_reg_write_i;
    logic [4:0]  mem_rd_i;
    logic [1:0]  mem_result_sel_i, mem_byte_off_i;
    logic [2:0]  mem_load_type_i;
    logic [31:0] mem_alu_result_i, mem_read_data_i, mem_pc_plus4_i;
    logic        reg_write_WE3_o;
    logic [4:0]  write_register_A3_o;
    logic [31:0] write_data_WD3_o;
    logic        wb_valid_o;
    logic [3:0]  retired_count_o;
`ifdef WB_FWD_EN
    logic        wb_fwd_valid_o;
    logic [4:0]  wb_fwd_rd_o;
    logic [31:0] wb_fwd_data_o;
`endif

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];
    vec_t cur;
    logic       m_valid = 1'b0;
    exp_t       m_ent;
    logic [3:0] m_cnt = 4'd0;

    always #5 clk = ~clk;

    writeback_stage #(
        .WIDTH(32),
        .SIZE (5),
        .CNT_W(4)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .stall_i            (stall_i),
        .flush_i            (flush_i),
        .mem_valid_i        (mem_valid_i),
        .mem_reg_write_i    (mem_reg_write_i),
        .mem_rd_i           (mem_rd_i),
        .mem_result_sel_i   (mem_result_sel_i),
        .mem_load_type_i    (mem_load_type_i),
        .mem_byte_off_i     (mem_byte_off_i),
        .mem_alu_result_i   (mem_alu_result_i),
        .mem_read_data_i    (mem_read_data_i),
        .mem_pc_plus4_i     (mem_pc_plus4_i),
        .reg_write_WE3_o    (reg_write_WE3_o),
        .write_register_A3_o(write_register_A3_o),
        .write_data_WD3_o   (write_data_WD3_o),
        .wb_valid_o         (wb_valid_o),
        .retired_count_o    (retired_count_o)
`ifdef WB_FWD_EN
        ,
        .wb_fwd_valid_o     (wb_fwd_valid_o),
        .wb_fwd_rd_o        (wb_fwd_rd_o),
        .wb_fwd_data_o      (wb_fwd_data_o)
`endif
    );

    function automatic vec_t mk(logic v, logic rw, logic [4:0] rd, logic [1:0] sel,
                                logic [2:0] lt, logic [1:0] off, logic [31:0] alu,
                                logic [31:0] rdata, logic [31:0] pc4, logic [31:0] exp_wd,
                                logic exp_we);
        vec_t t;
        t.valid = v;   t.rw = rw;   t.rd = rd;       t.sel = sel;       t.lt = lt;
        t.off = off;   t.alu = alu; t.rdata = rdata; t.pc4 = pc4;
        t.exp_wd = exp_wd; t.exp_we = exp_we;
        return t;
    endfunction

    task automatic apply(input vec_t t);
        cur              = t;
        mem_valid_i      = t.valid;
        mem_reg_write_i  = t.rw;
        mem_rd_i         = t.rd;
        mem_result_sel_i = t.sel;
        mem_load_type_i  = t.lt;
        mem_byte_off_i   = t.off;
        mem_alu_result_i = t.alu;
        mem_read_data_i  = t.rdata;
        mem_pc_plus4_i   = t.pc4;
    endtask

    // One clock: advance the expectation model, queue what WB should present.
    task automatic tick();
        @(posedge clk);
        if (m_valid && !stall_i) m_cnt = m_cnt + 4'd1;
        if (flush_i) begin
            m_valid = 1'b0;
        end else if (!stall_i) begin
            m_valid  = cur.valid;
            m_ent.we = cur.exp_we;
            m_ent.a3 = cur.rd;
            m_ent.wd = cur.exp_wd;
        end
        if (m_valid) exp_q.push_back(m_ent);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        m_valid = 1'b0;
        m_cnt   = 4'd0;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Monitor: every presented WB entry must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && wb_valid_o) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_entry: unexpected valid entry A3=%0d WD3=%h",
                             write_register_A3_o, write_data_WD3_o);
                end else begin
                    e = exp_q.pop_front();
                    if (reg_write_WE3_o !== e.we || write_register_A3_o !== e.a3 ||
                        write_data_WD3_o !== e.wd) begin
                        n_fail++;
                        $display("FAIL wb_entry: got WE3=%b A3=%0d WD3=%h, required WE3=%b A3=%0d WD3=%h",
                                 reg_write_WE3_o, write_register_A3_o, write_data_WD3_o,
                                 e.we, e.a3, e.wd);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t bub;
        bub     = mk(0, 0, 5'd0, RES_ALU, LD_W, 2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
        reset   = 1'b1;
        stall_i = 1'b0;
        flush_i = 1'b0;
        apply(mk(1, 1, 5'd9, RES_LINK, LD_B, 2'd3, 32'hAAAA_5555, 32'hFFFF_FFFF,
                 32'h1234_5678, 32'h0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("reset_we3", {31'd0, reg_write_WE3_o}, 32'd0);
        chk("reset_a3", {27'd0, write_register_A3_o}, 32'd0);
        chk("reset_wd3", write_data_WD3_o, 32'd0);
        chk("reset_count", {28'd0, retired_count_o}, 32'd0);
        reset = 1'b0;

        // ALU, loads, link, $zero and reg_write=0 cases
        apply(mk(1, 1, 5'd8, RES_ALU, LD_W, 2'd0, 32'h0000_1234, 32'h0, 32'h0, 32'h0000_1234, 1));
        tick();
        chk("add_we3", {31'd0, reg_write_WE3_o}, 32'd1);
        chk("add_wd3", write_data_WD3_o, 32'h0000_1234);
        apply(mk(1, 1, 5'd2, RES_LOAD, LD_B, 2'd3, 32'h0, 32'h80FF_0000, 32'h0, 32'hFFFF_FF80, 1));
        tick();
        apply(mk(1, 1, 5'd3, RES_LOAD, LD_BU, 2'd3, 32'h0, 32'h80FF_0000, 32'h0, 32'h0000_0080, 1));
        tick();
        apply(mk(1, 1, 5'd4, RES_LOAD, LD_H, 2'd2, 32'h0, 32'h80FF_0000, 32'h0, 32'hFFFF_80FF, 1));
        tick();
        apply(mk(1, 1, 5'd5, RES_LOAD, LD_HU, 2'd2, 32'h0, 32'h80FF_0000, 32'h0, 32'h0000_80FF, 1));
        tick();
        apply(mk(1, 1, 5'd6, RES_LOAD, LD_W, 2'd1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF, 1));
        tick();
        apply(mk(1, 1, 5'd7, RES_LOAD, LD_B, 2'd1, 32'h0, 32'h1234_5678, 32'h0, 32'h0000_0056, 1));
        tick();
        apply(mk(1, 1, 5'd10, RES_LOAD, LD_H, 2'd1, 32'h0, 32'h1234_F678, 32'h0, 32'hFFFF_F678, 1));
        tick();
        apply(mk(1, 1, 5'd11, RES_LOAD, 3'b111, 2'd2, 32'h0, 32'h8765_4321, 32'h0, 32'h8765_4321, 1));
        tick();
        apply(mk(1, 1, 5'd12, 2'b11, LD_B, 2'd0, 32'h0000_CAFE, 32'hFFFF_FFFF, 32'h0, 32'h0000_CAFE, 1));
        tick();
        apply(mk(1, 1, 5'd31, RES_LINK, LD_W, 2'd0, 32'h111, 32'h0, 32'h0040_0008, 32'h0040_0008, 1));
        tick();
        apply(mk(1, 1, 5'd0, RES_LINK, LD_W, 2'd0, 32'h111, 32'h0, 32'h0040_0008, 32'h0040_0008, 0));
        tick();
        apply(mk(1, 0, 5'd13, RES_ALU, LD_W, 2'd0, 32'h0000_0BAD, 32'h0, 32'h0, 32'h0000_0BAD, 0));
        tick();

        // Stall three cycles: entry held and rewritten, count frozen
        apply(mk(1, 1, 5'd5, RES_ALU, LD_W, 2'd0, 32'h0000_55AA, 32'h0, 32'h0, 32'h0000_55AA, 1));
        tick();
        stall_i = 1'b1;
        apply(mk(1, 1, 5'd14, RES_ALU, LD_W, 2'd0, 32'h0000_7777, 32'h0, 32'h0, 32'h0000_7777, 1));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_count", {28'd0, retired_count_o}, {28'd0, m_cnt});
            chk("stall_we3", {31'd0, reg_write_WE3_o}, 32'd1);
        end
        stall_i = 1'b0;
        tick();
        chk("unstall_count", {28'd0, retired_count_o}, {28'd0, m_cnt});

        // Stall and flush together: flush wins, no retirement since stalled
        stall_i = 1'b1;
        flush_i = 1'b1;
        apply(mk(1, 1, 5'd15, RES_ALU, LD_W, 2'd0, 32'h0000_9999, 32'h0, 32'h0, 32'h0000_9999, 1));
        tick();
        chk("flush_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("flush_we3", {31'd0, reg_write_WE3_o}, 32'd0);
        chk("flush_count", {28'd0, retired_count_o}, {28'd0, m_cnt});
        stall_i = 1'b0;
        flush_i = 1'b0;

        // Asynchronous reset mid-cycle with a valid entry in WB
        apply(mk(1, 1, 5'd20, RES_ALU, LD_W, 2'd0, 32'h0000_4242, 32'h0, 32'h0, 32'h0000_4242, 1));
        tick();
        #2 reset = 1'b1;
        #1;
        chk("async_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("async_we3", {31'd0, reg_write_WE3_o}, 32'd0);
        chk("async_a3", {27'd0, write_register_A3_o}, 32'd0);
        chk("async_wd3", write_data_WD3_o, 32'd0);
        chk("async_count", {28'd0, retired_count_o}, 32'd0);
        exp_q.delete();
        m_valid = 1'b0;
        m_cnt   = 4'd0;
        @(posedge clk);
        #1;
        chk("in_reset_we3", {31'd0, reg_write_WE3_o}, 32'd0);
        reset = 1'b0;

        // Five back-to-back retirements
        for (int i = 0; i < 5; i++) begin
            apply(mk(1, 1, 5'(i + 1), RES_ALU, LD_W, 2'd0, 32'(i * 3), 32'h0, 32'h0,
                     32'(i * 3), 1));
            tick();
        end
        apply(bub);
        tick();
        chk("count_5", {28'd0, retired_count_o}, 32'd5);

        // Seventeen retirements wrap a 4-bit counter to 1
        do_reset();
        for (int i = 0; i < 17; i++) begin
            apply(mk(1, 1, 5'd21, RES_ALU, LD_W, 2'd0, 32'h100 + 32'(i), 32'h0, 32'h0,
                     32'h100 + 32'(i), 1));
            tick();
        end
        apply(bub);
        tick();
        chk("count_wrap", {28'd0, retired_count_o}, 32'd1);

        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
